// File: rtl/xmem_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the HyperRAM wrapper.
package xmem_arb_pkg;

    localparam int unsigned ADR_W = 30;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic [DAT_W-1:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/xmem_arb_watchdog.sv
// Slave-ack watchdog: counts stalled strobe cycles and raises a one-cycle expire plus a sticky flag.
module xmem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stb,
    input  logic ack,
    output logic expire,
    output logic timeout_flag
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    // cnt holds the number of stalled cycles already elapsed, so expiry lands in stalled cycle N
    assign expire = stb && !ack && (cnt == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (!stb || ack || expire)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
            if (expire)
                timeout_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/xmem_arbiter.sv
// Two-master Wishbone arbiter (alternating tie-break, grant held for the whole cycle).
// Optional slave-ack watchdog enabled by defining XMEM_ARBITER_TIMEOUT_EN.
module xmem_arbiter
    import xmem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:ADR_W+1]   m0_adr_i,
    input  logic [0:DAT_W-1]   m0_dat_i,
    input  logic               m0_we_i,
    input  logic               m0_stb_i,
    input  logic               m0_cyc_i,
    input  logic [0:SEL_W-1]   m0_sel_i,
    output logic               m0_ack_o,
    output logic [0:DAT_W-1]   m0_dat_o,
    input  logic [2:ADR_W+1]   m1_adr_i,
    input  logic [0:DAT_W-1]   m1_dat_i,
    input  logic               m1_we_i,
    input  logic               m1_stb_i,
    input  logic               m1_cyc_i,
    input  logic [0:SEL_W-1]   m1_sel_i,
    output logic               m1_ack_o,
    output logic [0:DAT_W-1]   m1_dat_o,
    output logic [2:ADR_W+1]   s_adr_o,
    output logic [0:DAT_W-1]   s_dat_o,
    output logic [0:SEL_W-1]   s_sel_o,
    output logic               s_we_o,
    output logic               s_stb_o,
    output logic               s_cyc_o,
    input  logic [0:DAT_W-1]   s_dat_i,
    input  logic               s_ack_i,
    output logic               timeout_flag
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("xmem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_t state;
    logic       last_q;
    logic       run_q;
    logic       g0, g1;
    logic       stb_raw;
    logic       expire;
    logic       ack_any;
    logic [0:DAT_W-1] rd_data;

    // Reset release is registered so the first grant can happen on the second edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            run_q <= 1'b0;
        else
            run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            last_q <= 1'b1;
        end else if (run_q) begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                        state  <= GNT0;
                        last_q <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state  <= GNT1;
                        last_q <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state  <= GNT1;
                            last_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state  <= GNT0;
                            last_q <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign g0 = (state == GNT0);
    assign g1 = (state == GNT1);

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        if (g0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            stb_raw = m0_stb_i;
        end else if (g1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            stb_raw = m1_stb_i;
        end
    end

`ifdef XMEM_ARBITER_TIMEOUT_EN
    xmem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset_n      (reset_n),
        .stb          (stb_raw),
        .ack          (s_ack_i),
        .expire       (expire),
        .timeout_flag (timeout_flag)
    );
`else
    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign s_stb_o = stb_raw && !expire;
    assign ack_any = s_ack_i || expire;

    // Ack also requires the granted master's cyc, so an abandoned request never sees a late ack
    assign m0_ack_o = g0 && m0_cyc_i && ack_any;
    assign m1_ack_o = g1 && m1_cyc_i && ack_any;

    assign rd_data  = expire ? TIMEOUT_FILL : s_dat_i;
    assign m0_dat_o = reset_n ? rd_data : '0;
    assign m1_dat_o = reset_n ? rd_data : '0;

endmodule
